divider: RTL and testbench



---
 rtl/divider.sv | 135 +++++++++++++
 tb/tb_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, done pulse on completion.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             dz_pend;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] sh_next;
  logic             ge;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  assign a_mag = cond_neg(a, a[WIDTH-1]);
  assign b_mag = cond_neg(b, b[WIDTH-1]);
  // Most-negative / -1 wraps naturally: magnitude 0x8000 passes through unnegated.
  assign q_fin = cond_neg(sh_next, neg_q);
  assign r_fin = cond_neg(p_next[WIDTH-1:0], neg_r);
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_fin = sh_next;
  assign r_fin = p_next[WIDTH-1:0];
`endif

  // One restoring iteration: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    p_shift = {prem[WIDTH-1:0], shreg[WIDTH-1]};
    ge      = (p_shift >= {1'b0, dvs});
    p_next  = ge ? (p_shift - {1'b0, dvs}) : p_shift;
    sh_next = {shreg[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      dz_pend     <= 1'b0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= RUN;
            prem  <= '0;
            if (b == '0) begin
              // Raw dividend is kept so it can be returned as the remainder.
              dz_pend <= 1'b1;
              shreg   <= a;
              dvs     <= '0;
              count   <= CW'(1);
            end else begin
              dz_pend <= 1'b0;
              shreg   <= a_mag;
              dvs     <= b_mag;
              count   <= CW'(WIDTH);
            end
`ifdef DIVIDER_SIGNED_EN
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (dz_pend) begin
            q           <= '1;
            r           <= shreg;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            dz_pend     <= 1'b0;
            count       <= '0;
            state       <= IDLE;
          end else begin
            shreg <= sh_next;
            prem  <= p_next;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              q           <= q_fin;
              r           <= r_fin;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the restoring divider.
// Signed vectors are included when DIVIDER_SIGNED_EN is defined.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  divider #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [15:0] eq, input logic [15:0] er,
                              input logic edz);
    chk({tag, " q"}, 32'(q), 32'(eq));
    chk({tag, " r"}, 32'(r), 32'(er));
    chk({tag, " dz"}, 32'(div_by_zero), 32'(edz));
    tick();
    chk({tag, " done_pulse_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input int lat);
    launch(av, bv);
    if (!edz) chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    wait_done(tag, lat);
    check_result(tag, eq, er, edz);
  endtask

  initial begin
    int  dcnt;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("reset q", 32'(q), 32'd0);
    chk("reset r", 32'(r), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    tick();

    run_div("u100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
    run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
    run_div("5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 16);
    run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16);

    // Divide by zero, then a normal divide clears the flag; q holds while running.
    run_div("dz1234", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
    launch(16'd10, 16'd3);
    chk("hold_q_during_run", 32'(q), 32'h0000FFFF);
    chk("hold_dz_during_run", 32'(div_by_zero), 32'd1);
    wait_done("10_3", 16);
    check_result("10_3", 16'd3, 16'd1, 1'b0);

    // Start pulses while busy must be ignored.
    launch(16'd100, 16'd7);
    a = 16'd50;
    b = 16'd5;
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        start = (n == 3 || n == 10);
        tick();
        n++;
        if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk("hs done_seen", 32'(seen), 32'd1);
      chk("hs latency", 32'(n), 32'd16);
    end
    chk("hs q", 32'(q), 32'd14);
    chk("hs r", 32'(r), 32'd2);
    // Start in the done cycle is accepted.
    launch(16'd50, 16'd5);
    chk("hs2 done_dropped", 32'(done), 32'd0);
    chk("hs2 busy_rose", 32'(busy), 32'd1);
    wait_done("hs2", 16);
    check_result("hs2", 16'd10, 16'd0, 1'b0);

    // Reset mid-operation aborts with no done pulse.
    launch(16'd100, 16'd7);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid q", 32'(q), 32'd0);
    chk("rst_mid r", 32'(r), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("rst_mid no_done", 32'(dcnt), 32'd0);
    run_div("9_4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 16);

`ifdef DIVIDER_SIGNED_EN
    run_div("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 16);
    run_div("s_7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 16);
    run_div("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 16);
    run_div("s_dz", 16'hFF00, 16'd0, 16'hFFFF, 16'hFF00, 1'b1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
